// File: rtl/subterranean_duplex_sequencer.sv
// -----------------------------------------------------------------------------
// subterranean_duplex_sequencer
//
// Turns high-level host commands (INIT, ABSORB, ENCRYPT, DECRYPT, BLANK,
// SQUEEZE) into the matching series of single-round Subterranean duplex
// core transactions. Core output is never buffered here; it streams straight
// through to the host. A command only completes once the core has no output
// word left pending, so every produced word is consumed before done pulses.
//
// Ports
//   clk, arstn                       clock / asynchronous ACTIVE-HIGH reset
//   cmd, cmd_len, cmd_valid/ready    command channel (sampled at handshake)
//   data_in*, data_in_valid/ready    host words for ABSORB/ENCRYPT/DECRYPT
//   data_out*, data_out_valid/ready  core output, passed through
//   core_init                        one-cycle core state clear
//   core_oper                        00 absorb, 01 absorb+out, 10 enc, 11 dec
//   core_din*, core_din_valid/ready  core request channel
//   core_dout*, core_dout_valid      core output word
//   core_dout_ready                  host accept, passed through to the core
//   busy, done, err                  status: not idle / completion / bad opcode
// -----------------------------------------------------------------------------
module subterranean_duplex_sequencer #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic [2:0]           cmd,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [31:0]          data_in,
    input  logic [2:0]           data_in_size,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [31:0]          data_out,
    output logic [2:0]           data_out_size,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 core_init,
    output logic [1:0]           core_oper,
    output logic [31:0]          core_din,
    output logic [2:0]           core_din_size,
    output logic                 core_din_valid,
    input  logic                 core_din_ready,
    input  logic                 core_dout_valid,
    input  logic [31:0]          core_dout,
    input  logic [2:0]           core_dout_size,
    output logic                 core_dout_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_PASS,
        S_GEN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [1:0]           oper_q, oper_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 init_q, init_d;

    logic cmd_hs;
    logic core_hs;

    assign cmd_ready = (state_q == S_IDLE);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign core_hs   = core_din_valid && core_din_ready;

    // Output side is a pure pass-through in every state.
    assign data_out        = core_dout;
    assign data_out_size   = core_dout_size;
    assign data_out_valid  = core_dout_valid;
    assign core_dout_ready = data_out_ready;

    assign core_oper = oper_q;
    assign core_init = init_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);

    // Core request channel: host word in PASS, zero-length blank call in GEN.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        core_din       = '0;
        core_din_size  = '0;
        core_din_valid = 1'b0;
        data_in_ready  = 1'b0;
        case (state_q)
            S_PASS: begin
                core_din       = data_in;
                core_din_size  = data_in_size;
                core_din_valid = data_in_valid;
                data_in_ready  = core_din_ready;
            end
            S_GEN: begin
                core_din_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        oper_d  = oper_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    count_d = cmd_len;
                    case (cmd)
                        3'b000: state_d = S_INIT;
                        3'b001, 3'b010, 3'b011: begin
                            // ABSORB maps to plain absorb; ENCRYPT/DECRYPT share their low bits.
                            oper_d  = (cmd == 3'b001) ? 2'b00 : cmd[1:0];
                            state_d = (cmd_len == '0) ? S_DONE : S_PASS;
                        end
                        3'b100, 3'b101: begin
                            // BLANK -> absorb, SQUEEZE -> absorb with output.
                            oper_d  = {1'b0, cmd[0]};
                            state_d = (cmd_len == '0) ? S_DONE : S_GEN;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_INIT: state_d = S_DONE;
            S_PASS, S_GEN: begin
                // The core withholds din_ready while an output word is pending,
                // so this count naturally stalls under host output backpressure.
                if (core_hs) begin
                    count_d = count_q - LEN_WIDTH'(1);
                    if (count_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!core_dout_valid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses are registered from the next state so they line up with the state itself.
    assign init_d = (state_d == S_INIT);
    assign done_d = (state_d == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            state_q <= S_IDLE;
            count_q <= '0;
            oper_q  <= 2'b00;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            oper_q  <= oper_d;
            err_q   <= err_d;
            done_q  <= done_d;
            init_q  <= init_d;
        end
    end

endmodule

// File: tb/tb_subterranean_duplex_sequencer.sv
// -----------------------------------------------------------------------------
// tb_subterranean_duplex_sequencer
//
// Bench for the duplex command sequencer. A simple core emulator answers
// duplex calls, host drivers supply words and output backpressure, and a
// transaction-level model (calls left, expected words, expected output sizes,
// completion cycle) is compared against the DUT on every negative clock edge.
// Drivers update 1 time unit after the rising edge using handshake flags the
// monitor recorded on the preceding falling edge.
// -----------------------------------------------------------------------------
module tb_subterranean_duplex_sequencer;

    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic [2:0]    cmd = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   data_in = '0;
    logic [2:0]    data_in_size = '0;
    logic          data_in_valid = 1'b0;
    logic          data_in_ready;
    logic [31:0]   data_out;
    logic [2:0]    data_out_size;
    logic          data_out_valid;
    logic          data_out_ready = 1'b0;
    logic          core_init;
    logic [1:0]    core_oper;
    logic [31:0]   core_din;
    logic [2:0]    core_din_size;
    logic          core_din_valid;
    logic          core_din_ready;
    logic          core_dout_valid;
    logic [31:0]   core_dout;
    logic [2:0]    core_dout_size;
    logic          core_dout_ready;
    logic          busy, done, err;

    subterranean_duplex_sequencer #(.LEN_WIDTH(LW)) dut (
        .clk(clk), .arstn(arstn),
        .cmd(cmd), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .data_in(data_in), .data_in_size(data_in_size),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_size(data_out_size),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .core_init(core_init), .core_oper(core_oper),
        .core_din(core_din), .core_din_size(core_din_size),
        .core_din_valid(core_din_valid), .core_din_ready(core_din_ready),
        .core_dout_valid(core_dout_valid), .core_dout(core_dout),
        .core_dout_size(core_dout_size), .core_dout_ready(core_dout_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- handshake flags (monitor -> drivers) ----------------
    bit          hs_cmd, hs_data, hs_out, hs_core, hs_init;
    logic [1:0]  hs_oper;
    logic [31:0] hs_din;
    logic [2:0]  hs_size;

    // ---------------- stimulus knobs ----------------
    int out_mode      = 2;  // 0 random, 1 hold low, 2 hold high, 3 toggle
    bit core_stall_en = 1'b0;
    bit din_gap_en    = 1'b0;
    logic [34:0] host_q[$];  // {size, word}

    // ---------------- reference model ----------------
    localparam int K_NONE = 0, K_INIT = 1, K_PASS = 2, K_GEN = 3;
    longint      cyc = 0;
    bit          m_active = 1'b0;
    int          m_kind = K_NONE;
    int          m_calls_left = 0;
    logic [1:0]  m_oper = 2'b00;
    bit          m_err = 1'b0;
    longint      m_due = -1;
    bit          m_due_set = 1'b1;
    longint      m_init_at = -1;
    logic [34:0] m_host_exp[$];
    logic [2:0]  m_out_sizes[$];
    logic [34:0] ent;
    logic [2:0]  exp_sz;
    bit          exp_dv, exp_dr;

    // Observation log used by the directed literal checks.
    int          n_calls = 0, n_outs = 0, done_count = 0, init_count = 0;
    longint      acc_cyc = 0, init_cyc = 0, done_cyc = 0, rise_cyc = 0;
    longint      first_call_cyc = 0, last_call_cyc = 0, last_out_cyc = 0;
    logic [2:0]  out_log[$];
    bit          prev_cmd_ready = 1'b0;

    always @(negedge clk) begin
        cyc++;
        hs_cmd  = 1'b0;
        hs_data = 1'b0;
        hs_out  = 1'b0;
        hs_core = 1'b0;
        hs_init = 1'b0;
        if (arstn) begin
            check("rst_busy", busy, 0);
            check("rst_core_din_valid", core_din_valid, 0);
            check("rst_data_in_ready", data_in_ready, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_core_init", core_init, 0);
            m_active = 1'b0; m_kind = K_NONE; m_calls_left = 0; m_err = 1'b0;
            m_due = -1; m_due_set = 1'b1; m_init_at = -1;
            m_host_exp.delete(); m_out_sizes.delete();
            prev_cmd_ready = 1'b0;
        end else begin
            check("pt_data_out", data_out, core_dout);
            check("pt_data_out_size", data_out_size, core_dout_size);
            check("pt_data_out_valid", data_out_valid, core_dout_valid);
            check("pt_core_dout_ready", core_dout_ready, data_out_ready);
            check("cmd_ready", cmd_ready, !m_active);
            check("busy", busy, m_active);
            check("err", err, m_err);
            check("done", done, cyc == m_due);
            check("core_init", core_init, cyc == m_init_at);
            exp_dv = m_active && m_calls_left > 0 &&
                     (m_kind == K_GEN || (m_kind == K_PASS && data_in_valid));
            exp_dr = m_active && m_calls_left > 0 && m_kind == K_PASS && core_din_ready;
            check("core_din_valid", core_din_valid, exp_dv);
            check("data_in_ready", data_in_ready, exp_dr);

            if (cmd_ready && !prev_cmd_ready) rise_cyc = cyc;
            prev_cmd_ready = cmd_ready;
            if (core_init) begin init_count++; init_cyc = cyc; hs_init = 1'b1; end
            if (done) begin done_count++; done_cyc = cyc; end
            if (data_in_valid && data_in_ready) hs_data = 1'b1;

            if (core_din_valid && core_din_ready) begin
                hs_core = 1'b1; hs_oper = core_oper; hs_din = core_din; hs_size = core_din_size;
                if (n_calls == 0 || last_call_cyc != cyc - 1) first_call_cyc = cyc;
                last_call_cyc = cyc;
                n_calls++;
                if (m_calls_left == 0) begin
                    check("unexpected_core_call", 1, 0);
                end else begin
                    check("core_oper", core_oper, m_oper);
                    if (m_kind == K_PASS) begin
                        ent = (m_host_exp.size() > 0) ? m_host_exp.pop_front() : 35'h0;
                        check("core_din_word", core_din, ent[31:0]);
                        check("core_din_size", core_din_size, ent[34:32]);
                        exp_sz = ent[34:32];
                    end else begin
                        check("gen_din_zero", core_din, 0);
                        check("gen_size_zero", core_din_size, 0);
                        exp_sz = 3'd4;
                    end
                    if (m_oper != 2'b00) m_out_sizes.push_back(exp_sz);
                    m_calls_left--;
                end
            end

            if (data_out_valid && data_out_ready) begin
                hs_out = 1'b1;
                n_outs++;
                last_out_cyc = cyc;
                out_log.push_back(data_out_size);
                if (m_out_sizes.size() == 0) check("unexpected_output", 1, 0);
                else check("out_size", data_out_size, m_out_sizes.pop_front());
            end

            if (cyc == m_due) begin m_active = 1'b0; m_kind = K_NONE; end

            // Completion follows two cycles after the last call or last output consumed.
            if (m_active && !m_due_set && m_calls_left == 0 && m_out_sizes.size() == 0) begin
                m_due = cyc + 2; m_due_set = 1'b1;
            end

            if (cmd_valid && cmd_ready) begin
                hs_cmd = 1'b1; acc_cyc = cyc;
                m_active = 1'b1; m_due_set = 1'b0; m_calls_left = 0;
                case (cmd)
                    3'd0: begin
                        m_kind = K_INIT; m_init_at = cyc + 1;
                        m_due = cyc + 2; m_due_set = 1'b1;
                    end
                    3'd1, 3'd2, 3'd3: begin
                        m_kind = K_PASS; m_calls_left = int'(cmd_len);
                        m_oper = (cmd == 3'd1) ? 2'b00 : ((cmd == 3'd2) ? 2'b10 : 2'b11);
                    end
                    3'd4, 3'd5: begin
                        m_kind = K_GEN; m_calls_left = int'(cmd_len);
                        m_oper = (cmd == 3'd4) ? 2'b00 : 2'b01;
                    end
                    default: begin
                        m_kind = K_NONE; m_err = 1'b1;
                        m_due = cyc + 1; m_due_set = 1'b1;
                    end
                endcase
                if (cmd != 3'd0 && cmd_len == '0 && !m_due_set) begin
                    m_due = cyc + 1; m_due_set = 1'b1;
                end
            end
        end
    end

    // ---------------- core emulator ----------------
    logic [23:0] core_ctr = '0;
    initial begin
        core_din_ready  = 1'b0;
        core_dout_valid = 1'b0;
        core_dout       = '0;
        core_dout_size  = '0;
        forever begin
            @(posedge clk); #1;
            if (hs_out) core_dout_valid = 1'b0;
            if (hs_init) begin core_dout_valid = 1'b0; core_ctr = '0; end
            if (hs_core && hs_oper != 2'b00) begin
                core_dout_valid = 1'b1;
                core_dout       = hs_din ^ {core_ctr, 8'h5a};
                core_dout_size  = (hs_oper == 2'b01) ? 3'd4 : hs_size;
            end
            if (hs_core) core_ctr++;
            core_din_ready = !core_dout_valid && (!core_stall_en || $urandom_range(0, 3) != 0);
        end
    end

    // ---------------- host data driver ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            if (hs_data && host_q.size() > 0) void'(host_q.pop_front());
            if (data_in_valid && !hs_data && host_q.size() > 0) begin
                // hold the offered word until it is taken
            end else if (host_q.size() > 0 && (!din_gap_en || $urandom_range(0, 2) != 0)) begin
                data_in_valid = 1'b1;
                data_in       = host_q[0][31:0];
                data_in_size  = host_q[0][34:32];
            end else begin
                data_in_valid = 1'b0;
                data_in       = $urandom;
                data_in_size  = 3'($urandom_range(0, 4));
            end
        end
    end

    // ---------------- host output-ready driver ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            case (out_mode)
                0:       data_out_ready = 1'($urandom_range(0, 1));
                1:       data_out_ready = 1'b0;
                3:       data_out_ready = ~data_out_ready;
                default: data_out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- main sequence ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_word(input logic [31:0] w, input logic [2:0] s);
        host_q.push_back({s, w});
        m_host_exp.push_back({s, w});
    endtask

    task automatic issue(input logic [2:0] c, input logic [LW-1:0] len);
        bit got;
        got = 1'b0;
        tick();
        cmd = c; cmd_len = len; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (hs_cmd) begin got = 1'b1; break; end
        end
        cmd_valid = 1'b0;
        if (!got) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input int base);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_count > base) begin got = 1'b1; break; end
            tick();
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic run_cmd(input logic [2:0] c, input logic [LW-1:0] len);
        int base;
        base = done_count;
        issue(c, len);
        wait_done(base);
    endtask

    initial begin
        int b_calls, b_outs, b_done, b_init, b_log;
        logic [2:0] c;
        logic [LW-1:0] len;

        #1 arstn = 1'b1;
        repeat (3) @(negedge clk);
        #1 arstn = 1'b0;
        @(negedge clk); #1;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_core_din_valid", core_din_valid, 0);
        check("reset_data_in_ready", data_in_ready, 0);

        // INIT latency: core_init at T+1, done at T+2, cmd_ready back at T+3.
        b_init = init_count;
        run_cmd(3'd0, 8'd5);
        repeat (2) tick();
        check("t2_init_once", init_count - b_init, 1);
        check("t2_init_lat", 32'(init_cyc - acc_cyc), 1);
        check("t2_done_lat", 32'(done_cyc - acc_cyc), 2);
        check("t2_ready_lat", 32'(rise_cyc - acc_cyc), 3);

        // BLANK len=8 with an always-ready core: eight back-to-back calls.
        out_mode = 0; core_stall_en = 1'b0;
        b_calls = n_calls; b_outs = n_outs; b_done = done_count;
        run_cmd(3'd4, 8'd8);
        repeat (2) tick();
        check("t3_calls", n_calls - b_calls, 8);
        check("t3_consecutive", 32'(last_call_cyc - first_call_cyc), 7);
        check("t3_no_output", n_outs - b_outs, 0);
        check("t3_done_once", done_count - b_done, 1);

        // ENCRYPT len=3 with sizes 4,4,2 and toggling output ready.
        out_mode = 3;
        push_word(32'h1111_2222, 3'd4);
        push_word(32'h3333_4444, 3'd4);
        push_word(32'h5555_6666, 3'd2);
        b_calls = n_calls; b_log = out_log.size();
        run_cmd(3'd2, 8'd3);
        check("t4_calls", n_calls - b_calls, 3);
        check("t4_outs", out_log.size() - b_log, 3);
        if (out_log.size() >= b_log + 3) begin
            check("t4_size0", out_log[b_log], 4);
            check("t4_size1", out_log[b_log + 1], 4);
            check("t4_size2", out_log[b_log + 2], 2);
        end
        check("t4_done_after_out", 32'(done_cyc - last_out_cyc), 2);

        // SQUEEZE len=4 with output held off for 10 cycles.
        out_mode = 1;
        b_calls = n_calls; b_log = out_log.size(); b_done = done_count;
        issue(3'd5, 8'd4);
        repeat (10) tick();
        check("t5_one_call_stalled", n_calls - b_calls, 1);
        check("t5_no_done_stalled", done_count - b_done, 0);
        out_mode = 2;
        wait_done(b_done);
        check("t5_calls", n_calls - b_calls, 4);
        check("t5_outs", out_log.size() - b_log, 4);
        for (int i = 0; i < 4; i++)
            if (out_log.size() > b_log + i) check("t5_size", out_log[b_log + i], 4);

        // ABSORB len=0 completes without core traffic; illegal opcode sets sticky err.
        b_calls = n_calls;
        run_cmd(3'd1, 8'd0);
        check("t6_no_calls", n_calls - b_calls, 0);
        check("t6_done_lat", 32'(done_cyc - acc_cyc), 1);
        run_cmd(3'd6, 8'd3);
        tick();
        check("t6_err_set", err, 1);
        run_cmd(3'd0, 8'd0);
        tick();
        check("t6_err_sticky", err, 1);

        // Randomized command mix.
        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 2)       c = 3'd0;
            else if (r == 15) c = 3'd6 | 3'($urandom_range(0, 1));
            else             c = 3'($urandom_range(1, 5));
            len = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 10));
            r = $urandom_range(0, 2);
            out_mode      = (r == 0) ? 0 : ((r == 1) ? 2 : 3);
            core_stall_en = 1'($urandom_range(0, 1));
            din_gap_en    = 1'($urandom_range(0, 1));
            if (c >= 3'd1 && c <= 3'd3)
                for (int i = 0; i < int'(len); i++)
                    push_word($urandom, 3'($urandom_range(0, 4)));
            run_cmd(c, len);
        end

        // Reset in the middle of BLANK len=8 after three calls.
        out_mode = 2; core_stall_en = 1'b0; din_gap_en = 1'b0;
        b_calls = n_calls;
        issue(3'd4, 8'd8);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (n_calls - b_calls >= 3) break;
        end
        check("t1_three_calls", n_calls - b_calls, 3);
        arstn = 1'b1;
        host_q.delete();
        @(negedge clk); #1;
        check("t1_din_valid", core_din_valid, 0);
        check("t1_busy", busy, 0);
        check("t1_err", err, 0);
        arstn = 1'b0;
        @(negedge clk); #1;
        check("t1_cmd_ready", cmd_ready, 1);
        b_done = done_count;
        run_cmd(3'd0, 8'd0);
        check("t1_init_after_reset", done_count - b_done, 1);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
